mvau_weight_streamer: RTL and testbench
=======================================

// Module: mvau_weight_streamer
// PURPOSE
//  Address generator and stream buffer wrapped around one PE's weight memory. On start it sweeps
//  wmem_addr 0..WMEM_DEPTH-1, repeated NUM_REPS times: one sweep per output pixel.
//  It absorbs the memory's 1-cycle registered read latency and presents words as a ready/valid stream to the PE datapath.
//  It never drops or duplicates a word under any backpressure pattern.
// PARAMETERS
//  SIMD          2   weights per word
//  TW            1   bits per weight
//  WMEM_DEPTH    4   words per sweep, (KDim^2*IFMCh*OFMCh)/(SIMD*PE), >=2
//  WMEM_ADDR_BW  4   address width, >= clog2(WMEM_DEPTH)
//  NUM_REPS      4   sweeps per frame, >=1
// PORTS
//  aclk         in   1              clock, all logic on rising edge
//  areset       in   1              asynchronous, active-high reset
//  start        in   1              1-cycle pulse, begins a frame; ignored unless IDLE
//  wmem_addr    out  WMEM_ADDR_BW   read address to weight memory
//  wmem_rd      out  1              read issued this cycle (address valid)
//  wmem_rdata   in   SIMD*TW        memory data, valid 1 cycle after wmem_rd
//  w_tdata      out  SIMD*TW        weight word to PE
//  w_tvalid     out  1              w_tdata valid
//  w_tready     in   1              PE accepts word
//  w_tlast      out  1              word is address WMEM_DEPTH-1 (end of sweep)
//  busy         out  1              high from start accept until done
//  done         out  1              1-cycle pulse after last word of frame accepted
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - wmem_addr=0, wmem_rd=0, w_tvalid=0, w_tlast=0, w_tdata=0, busy=0, done=0
//   - FIFO empty, counters 0, state IDLE
//  FSM
//   - IDLE -> RUN on start
//   - RUN -> DRAIN when the final read (addr WMEM_DEPTH-1, rep NUM_REPS-1) issues
//   - DRAIN -> IDLE when the FIFO is empty, nothing is in flight, and the last word was accepted
//   - done pulses in the cycle after that acceptance; busy=1 in RUN and DRAIN
//   - start during RUN/DRAIN is ignored
//  Read issue (RUN only)
//   - wmem_rd=1 iff fifo_count + inflight - pop < 2, where pop = w_tvalid & w_tready
//   - This guarantees at most 2 words are ever held (FIFO plus in-flight) and never overflows.
//  Addressing
//   - addr increments on each wmem_rd
//   - at WMEM_DEPTH-1 it wraps to 0 and rep increments; there is no gap cycle between sweeps
//  Read data
//   - inflight is a 1-bit register = last cycle's wmem_rd
//   - when set, wmem_rdata is pushed into the FIFO; its tag bit is the registered (addr==WMEM_DEPTH-1)
//  Stream
//   - w_tvalid = FIFO not empty; w_tdata and w_tlast come from the FIFO head
//   - data/last are held stable while valid and !ready (AXI-stream rule)
//  Throughput and latency
//   - With w_tready tied high: one word per cycle sustained
//   - First w_tvalid is 2 cycles after start (cycle 0 start, cycle 1 first rd, cycle 2 valid).
//  Boundary cases
//   - Push and pop in the same cycle at count 1 or 2: count is unchanged, order preserved.
//   - w_tready low for any duration: reads stall at most 2 ahead.
//   - Reset asserted mid-frame: immediate return to reset state. Words in flight are discarded, no done pulse.
// STRUCTURE
//  - Package mvau_defs_pkg:
//     - typedef enum logic [1:0] {WS_IDLE, WS_RUN, WS_DRAIN} wstream_state_t
//     - localparam function for the rep-counter width, clog2(NUM_REPS)
//  - Sub-module mvau_wstream_fifo2:
//     - 2-entry FIFO, width SIMD*TW+1 (data+last), same aclk/areset
//     - push, pop, full, empty, count[1:0] ports
//     - simultaneous push/pop legal when not empty
//  - Top level holds the FSM, address/rep counters, inflight flag and the issue-credit logic.
// TESTING
//  - Bench model: memory model with 1-cycle registered read, word[a] = a+8'h10
//  1. WMEM_DEPTH=4, NUM_REPS=2, ready=1: start ->
//     data 10,11,12,13,10,11,12,13 on 8 consecutive cycles from cycle 2
//     tlast on the 4th and 8th words; done 1 cycle after the 8th
//  2. Same config, ready toggling 1010..:
//     identical 8-word sequence, no drop/duplicate
//     wmem_rd never leaves fifo_count+inflight > 2
//  3. ready=0 for 10 cycles after start:
//     exactly 2 reads issued, w_tdata=10 held stable
//     on release, the stream resumes 11,12,...
//  4. Second start pulse during RUN:
//     ignored; total words = WMEM_DEPTH*NUM_REPS, single done
//  5. areset asserted after word 3 accepted:
//     all outputs return to reset values asynchronously, no done
//     a new start after release restarts at addr 0 with data 10
//  6. WMEM_DEPTH=2, NUM_REPS=1:
//     words 10,11, tlast on 11
//     FSM goes RUN->DRAIN->IDLE, busy falls with done

Source files
------------

// File: rtl/mvau_weight_streamer_pkg.sv
// Shared types and sizing helpers for the MVAU weight streamer.
package mvau_defs_pkg;

    typedef enum logic [1:0] {
        WS_IDLE  = 2'd0,
        WS_RUN   = 2'd1,
        WS_DRAIN = 2'd2
    } wstream_state_t;

    // Rep counter must hold 0..num_reps-1 and never collapse to zero width.
    function automatic int rep_cnt_bw(input int num_reps);
        return (num_reps > 1) ? $clog2(num_reps) : 1;
    endfunction

endpackage

// File: rtl/mvau_weight_streamer_if.sv
// Weight-memory read port plus the weight stream toward the PE datapath.
interface mvau_weight_streamer_if #(
    parameter int DW = 2,
    parameter int AW = 4
);
    logic [AW-1:0] wmem_addr;
    logic          wmem_rd;
    logic [DW-1:0] wmem_rdata;
    logic [DW-1:0] w_tdata;
    logic          w_tvalid;
    logic          w_tready;
    logic          w_tlast;

    modport master (
        output wmem_addr, wmem_rd, w_tdata, w_tvalid, w_tlast,
        input  wmem_rdata, w_tready
    );

    modport slave (
        input  wmem_addr, wmem_rd, w_tdata, w_tvalid, w_tlast,
        output wmem_rdata, w_tready
    );
endinterface

// File: rtl/mvau_weight_streamer_fifo2.sv
// Two-entry stream buffer with fall-through when empty, so a word arriving
// from memory is visible to the consumer in the same cycle it is pushed.
module mvau_wstream_fifo2 #(
    parameter int W = 3
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         i_push,
    input  logic [W-1:0] i_pdata,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);
    logic [1:0][W-1:0] r_mem;
    logic [1:0]        r_count;
    logic              r_wp;
    logic              r_rp;
    logic              w_bypass;
    logic              w_wr;
    logic              w_adv;

    assign o_empty  = (r_count == 2'd0);
    assign o_full   = (r_count == 2'd2);
    assign o_count  = r_count;
    assign w_bypass = o_empty & i_push & i_pop;
    assign w_wr     = i_push & ~w_bypass;
    assign w_adv    = i_pop & ~o_empty;

    // Zero when nothing is presented so the stream outputs idle at 0.
    assign o_head = !o_empty ? r_mem[r_rp] : (i_push ? i_pdata : '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_mem   <= '0;
            r_count <= 2'd0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= i_pdata;
                r_wp        <= ~r_wp;
            end
            if (w_adv) r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end
endmodule

// File: rtl/mvau_weight_streamer.sv
// Sweeps the PE weight memory NUM_REPS times per frame and re-times the
// 1-cycle read data into a ready/valid stream with a two-word credit.
module mvau_weight_streamer
    import mvau_defs_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int NUM_REPS     = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    mvau_weight_streamer_if.master bus
);
    localparam int DW  = SIMD * TW;
    localparam int RBW = rep_cnt_bw(NUM_REPS);

    localparam logic [1:0] S_IDLE  = WS_IDLE;
    localparam logic [1:0] S_RUN   = WS_RUN;
    localparam logic [1:0] S_DRAIN = WS_DRAIN;

    logic [1:0]              r_state;
    logic [WMEM_ADDR_BW-1:0] r_addr;
    logic [RBW-1:0]          r_rep;
    logic                    r_inflight;
    logic                    r_tag;
    logic                    r_done;

    logic          w_addr_end;
    logic          w_rep_end;
    logic          w_vld;
    logic          w_pop;
    logic          w_rd;
    logic          w_final_acc;
    logic [2:0]    w_occ;
    logic [DW:0]   w_head;
    logic [1:0]    w_count;
    logic          w_full;
    logic          w_empty;

    assign w_addr_end = (r_addr == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
    assign w_rep_end  = (r_rep == RBW'(NUM_REPS - 1));
    assign w_vld      = ~w_empty | r_inflight;
    assign w_pop      = w_vld & bus.w_tready;

    // Words held = buffered + the read whose data lands this cycle.
    assign w_occ = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_rd  = (r_state == S_RUN) && (w_occ < (3'd2 + {2'b00, w_pop}))
                   && !(w_full && !w_pop);

    // In DRAIN every remaining word belongs to the frame, so popping the
    // sole remaining one is the final acceptance.
    assign w_final_acc = (r_state == S_DRAIN) && w_pop && (w_occ == 3'd1);

    mvau_wstream_fifo2 #(.W(DW + 1)) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .i_push  (r_inflight),
        .i_pdata ({r_tag, bus.wmem_rdata}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rep      <= '0;
            r_inflight <= 1'b0;
            r_tag      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            r_tag      <= w_rd & w_addr_end;
            r_done     <= w_final_acc;
            case (r_state)
                S_IDLE:  if (i_start) r_state <= S_RUN;
                S_RUN:   if (w_rd && w_addr_end && w_rep_end) r_state <= S_DRAIN;
                S_DRAIN: if (w_final_acc) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_rd) begin
                if (w_addr_end) begin
                    r_addr <= '0;
                    r_rep  <= w_rep_end ? '0 : r_rep + RBW'(1);
                end else begin
                    r_addr <= r_addr + WMEM_ADDR_BW'(1);
                end
            end
        end
    end

    assign bus.wmem_addr = r_addr;
    assign bus.wmem_rd   = w_rd;
    assign bus.w_tdata   = w_head[DW-1:0];
    assign bus.w_tlast   = w_head[DW];
    assign bus.w_tvalid  = w_vld;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
endmodule

// File: tb/tb_mvau_weight_streamer.sv
// Self-checking bench: two streamer configurations against a frame-level model.
module tb_mvau_weight_streamer;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    mvau_weight_streamer_if #(.DW(DW), .AW(4)) bus_a ();
    mvau_weight_streamer_if #(.DW(DW), .AW(4)) bus_b ();

    mvau_weight_streamer #(.SIMD(8), .TW(1), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4), .NUM_REPS(2)) u_a (
        .aclk(clk), .areset(rst_a), .i_start(start_a), .o_busy(busy_a), .o_done(done_a), .bus(bus_a)
    );
    mvau_weight_streamer #(.SIMD(8), .TW(1), .WMEM_DEPTH(2), .WMEM_ADDR_BW(4), .NUM_REPS(1)) u_b (
        .aclk(clk), .areset(rst_b), .i_start(start_b), .o_busy(busy_b), .o_done(done_b), .bus(bus_b)
    );

    // Weight memories: registered read, word[a] = a + 0x10.
    always @(posedge clk) if (bus_a.wmem_rd) bus_a.wmem_rdata <= 8'(bus_a.wmem_addr) + 8'h10;
    always @(posedge clk) if (bus_b.wmem_rd) bus_b.wmem_rdata <= 8'(bus_b.wmem_addr) + 8'h10;

    int n_chk = 0, n_err = 0;
    int exp_done_lat[2];
    int exp_probe_cyc[2];
    int exp_probe_rd[2];

    bit m_busy[2], m_dexp[2], m_stall[2], m_first[2];
    int m_acc[2], m_rd[2], m_cyc[2], m_pd[2], m_pl[2];

    task automatic ck(input string nm, input int id, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, id, $time, got, exp);
        end
    endtask

    task automatic mdl(input int id, input bit is_neg, input bit rst, input bit st,
                       input int addr, input bit rd, input int data, input bit vld,
                       input bit rdy, input bit last, input bit busy, input bit done,
                       input int depth, input int reps);
        int total; bit ob; bit fin;
        total = depth * reps;
        if (rst) begin
            ck("reset_outputs", id, addr + int'(rd) + data + int'(vld) + int'(last) + int'(busy) + int'(done), 0);
            m_busy[id] = 0; m_dexp[id] = 0; m_stall[id] = 0; m_first[id] = 0;
            m_acc[id] = 0; m_rd[id] = 0; m_cyc[id] = 0;
            return;
        end
        if (!is_neg) return;
        ob  = m_busy[id];
        fin = 0;
        m_cyc[id]++;
        ck("busy", id, int'(busy), int'(ob));
        ck("done", id, int'(done), int'(m_dexp[id]));
        if (done && exp_done_lat[id] >= 0) ck("done_latency", id, m_cyc[id], exp_done_lat[id]);
        if (!ob) ck("idle_quiet", id, int'(vld) + int'(rd), 0);
        if (m_stall[id]) begin
            ck("hold_valid", id, int'(vld), 1);
            ck("hold_data", id, data, m_pd[id]);
            ck("hold_last", id, int'(last), m_pl[id]);
        end
        if (ob && vld && !m_first[id]) begin
            ck("first_valid_cycle", id, m_cyc[id], 2);
            m_first[id] = 1;
        end
        if (rd) begin
            ck("rd_addr", id, addr, m_rd[id] % depth);
            ck("rd_in_frame", id, int'(m_rd[id] < total), 1);
            m_rd[id]++;
        end
        if (vld && rdy) begin
            ck("w_tdata", id, data, (m_acc[id] % depth) + 16);
            ck("w_tlast", id, int'(last), int'((m_acc[id] % depth) == depth - 1));
            m_acc[id]++;
            if (m_acc[id] == total) fin = 1;
        end
        if (ob) ck("held_le2", id, int'((m_rd[id] - m_acc[id]) <= 2), 1);
        if (ob && m_cyc[id] == exp_probe_cyc[id]) ck("stall_reads", id, m_rd[id], exp_probe_rd[id]);
        if (ob && m_cyc[id] > 500) begin
            ck("timeout", id, 0, 1);
            fin = 1;
        end
        m_dexp[id] = fin;
        if (fin) m_busy[id] = 0;
        m_stall[id] = vld && !rdy;
        m_pd[id] = data;
        m_pl[id] = int'(last);
        if (st && !ob) begin
            m_busy[id] = 1; m_acc[id] = 0; m_rd[id] = 0; m_cyc[id] = 0; m_first[id] = 0;
        end
    endtask

    initial forever begin
        @(negedge clk or posedge rst_a or posedge rst_b);
        #1;
        mdl(0, !clk, rst_a, start_a, int'(bus_a.wmem_addr), bus_a.wmem_rd, int'(bus_a.w_tdata),
            bus_a.w_tvalid, bus_a.w_tready, bus_a.w_tlast, busy_a, done_a, 4, 2);
        mdl(1, !clk, rst_b, start_b, int'(bus_b.wmem_addr), bus_b.wmem_rd, int'(bus_b.w_tdata),
            bus_b.w_tvalid, bus_b.w_tready, bus_b.w_tlast, busy_b, done_b, 2, 1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: ready 1010.., 2: ready low cycles 0..10,
    // 3: extra start at cycle 3, 4: reset at cycle 5 (after word 3)
    task automatic run_a(input int mode, input int dlat, input int pcyc, input int prd);
        bit fin;
        fin = 0;
        exp_done_lat[0] = dlat; exp_probe_cyc[0] = pcyc; exp_probe_rd[0] = prd;
        for (int c = 0; c < 400 && !fin; c++) begin
            start_a = (c == 0) || (mode == 3 && c == 3);
            case (mode)
                1:       bus_a.w_tready = (c % 2 == 0);
                2:       bus_a.w_tready = (c > 10);
                default: bus_a.w_tready = 1'b1;
            endcase
            if (mode == 4 && c == 5) rst_a = 1'b1;
            if (mode == 4 && c == 8) begin rst_a = 1'b0; fin = 1; end
            @(posedge clk); #1;
            if (done_a) fin = 1;
        end
        start_a = 1'b0;
        bus_a.w_tready = 1'b1;
    endtask

    task automatic run_b(input int dlat);
        bit fin;
        fin = 0;
        exp_done_lat[1] = dlat;
        for (int c = 0; c < 400 && !fin; c++) begin
            start_b = (c == 0);
            @(posedge clk); #1;
            if (done_b) fin = 1;
        end
        start_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_done_lat[i] = -1; exp_probe_cyc[i] = -1; exp_probe_rd[i] = 0;
        end
        bus_a.w_tready = 1'b1;
        bus_b.w_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(2);
        run_a(0, 10, -1, 0);   // back-to-back stream, done at cycle 10
        idle(3);
        run_a(1, -1, -1, 0);   // alternating backpressure
        idle(3);
        run_a(2, 19, 10, 2);   // long stall: 2 reads, then resume
        idle(3);
        run_a(3, 10, -1, 0);   // second start ignored
        idle(3);
        run_a(4, -1, -1, 0);   // async reset mid-frame
        idle(3);
        run_a(0, 10, -1, 0);   // restart from address 0
        idle(3);
        run_b(4);              // depth 2, one rep
        idle(4);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
